alu_issue_stage: RTL and testbench

- ID/EX pipeline register feeding the 32-bit ALU; the producer side of the ALU's op/operand interface.
- Decodes ALUOp class, funct and opcode into the 4-bit ALU op code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 15 none.
- Registers operands and destination with stall/flush control.
- Applies EX/MEM and MEM/WB forwarding to the registered operands before they reach the ALU.

---
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register for the 32-bit ALU: op decode, operand capture and EX/MEM, MEM/WB forwarding.
// Optional ALU_ISSUE_ILLEGAL_CNT_EN adds a saturating count of captured illegal instructions.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_id_valid,
  input  logic [1:0]    i_id_alu_class,
  input  logic [5:0]    i_id_funct,
  input  logic [5:0]    i_id_opcode,
  input  logic [DW-1:0] i_id_rs_data,
  input  logic [DW-1:0] i_id_rt_data,
  input  logic [DW-1:0] i_id_imm,
  input  logic          i_id_alu_src,
  input  logic [RW-1:0] i_id_dest,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic [1:0]    i_fwd_a,
  input  logic [1:0]    i_fwd_b,
  input  logic [DW-1:0] i_ex_mem_data,
  input  logic [DW-1:0] i_mem_wb_data,
  output logic          o_ex_valid,
  output logic [3:0]    o_ex_alu_op,
  output logic [DW-1:0] o_ex_operand_a,
  output logic [DW-1:0] o_ex_operand_b,
  output logic [DW-1:0] o_ex_store_data,
  output logic [RW-1:0] o_ex_dest,
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  output logic [15:0]   o_illegal_cnt,
`endif
  output logic          o_ex_illegal
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NONE = 4'd15;

  logic [3:0]    w_op;
  logic          w_illegal;

  logic          r_valid;
  logic [3:0]    r_op;
  logic          r_illegal;
  logic [RW-1:0] r_dest;
  logic [DW-1:0] r_rs;
  logic [DW-1:0] r_rt;
  logic [DW-1:0] r_imm;
  logic          r_alu_src;

  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic          w_capture;

  always_comb begin
    w_op      = OP_NONE;
    w_illegal = 1'b0;
    unique case (i_id_alu_class)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (i_id_funct)
          6'h20:   w_op = OP_ADD;
          6'h22:   w_op = OP_SUB;
          6'h24:   w_op = OP_AND;
          6'h25:   w_op = OP_OR;
          6'h2A:   w_op = OP_SLT;
          default: w_illegal = 1'b1;
        endcase
      end
      default: begin
        case (i_id_opcode)
          6'h08:   w_op = OP_ADD;
          6'h0C:   w_op = OP_AND;
          6'h0D:   w_op = OP_OR;
          6'h0A:   w_op = OP_SLT;
          default: w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Flush outranks stall; an idle ID slot is captured as a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_flush || (!i_stall && !i_id_valid)) begin
      r_valid   <= 1'b0;
      r_op      <= OP_NONE;
      r_illegal <= 1'b0;
      r_dest    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm     <= '0;
      r_alu_src <= 1'b0;
    end else if (!i_stall) begin
      r_valid   <= 1'b1;
      r_op      <= w_op;
      r_illegal <= w_illegal;
      r_dest    <= i_id_dest;
      r_rs      <= i_id_rs_data;
      r_rt      <= i_id_rt_data;
      r_imm     <= i_id_imm;
      r_alu_src <= i_id_alu_src;
    end
  end

  assign w_capture = i_id_valid && !i_stall && !i_flush;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] r_illegal_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_capture && w_illegal && (r_illegal_cnt != 16'hFFFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end

  assign o_illegal_cnt = r_illegal_cnt;
`else
  logic w_unused_capture;
  assign w_unused_capture = w_capture;
`endif

  always_comb begin
    unique case (i_fwd_a)
      2'b10:   w_fwd_a = i_ex_mem_data;
      2'b01:   w_fwd_a = i_mem_wb_data;
      default: w_fwd_a = r_rs;
    endcase
    unique case (i_fwd_b)
      2'b10:   w_fwd_b = i_ex_mem_data;
      2'b01:   w_fwd_b = i_mem_wb_data;
      default: w_fwd_b = r_rt;
    endcase
  end

  // Gating keeps a bubble's ALU result at zero regardless of forwarding.
  assign o_ex_valid      = r_valid;
  assign o_ex_alu_op     = r_op;
  assign o_ex_illegal    = r_illegal;
  assign o_ex_dest       = r_dest;
  assign o_ex_operand_a  = r_valid ? w_fwd_a : '0;
  assign o_ex_store_data = r_valid ? w_fwd_b : '0;
  assign o_ex_operand_b  = !r_valid ? '0 : (r_alu_src ? r_imm : w_fwd_b);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; exercises the illegal counter when ALU_ISSUE_ILLEGAL_CNT_EN is defined.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  id_alu_class;
  logic [5:0]  id_funct;
  logic [5:0]  id_opcode;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        id_alu_src;
  logic [4:0]  id_dest;
  logic        stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] ex_mem_data;
  logic [31:0] mem_wb_data;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_operand_a;
  logic [31:0] ex_operand_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_id_valid      (id_valid),
    .i_id_alu_class  (id_alu_class),
    .i_id_funct      (id_funct),
    .i_id_opcode     (id_opcode),
    .i_id_rs_data    (id_rs_data),
    .i_id_rt_data    (id_rt_data),
    .i_id_imm        (id_imm),
    .i_id_alu_src    (id_alu_src),
    .i_id_dest       (id_dest),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_fwd_a         (fwd_a),
    .i_fwd_b         (fwd_b),
    .i_ex_mem_data   (ex_mem_data),
    .i_mem_wb_data   (mem_wb_data),
    .o_ex_valid      (ex_valid),
    .o_ex_alu_op     (ex_alu_op),
    .o_ex_operand_a  (ex_operand_a),
    .o_ex_operand_b  (ex_operand_b),
    .o_ex_store_data (ex_store_data),
    .o_ex_dest       (ex_dest),
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    .o_illegal_cnt   (illegal_cnt),
`endif
    .o_ex_illegal    (ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] cls, input logic [5:0] fn,
                       input logic [5:0] opc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic src, input logic [4:0] dst);
    id_valid = v; id_alu_class = cls; id_funct = fn; id_opcode = opc;
    id_rs_data = rs; id_rt_data = rt; id_imm = imm; id_alu_src = src; id_dest = dst;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_op"}, {28'd0, ex_alu_op}, 32'hF);
    chk({tag, "_ill"}, {31'd0, ex_illegal}, 32'd0);
    chk({tag, "_dest"}, {27'd0, ex_dest}, 32'd0);
    chk({tag, "_a"}, ex_operand_a, 32'd0);
    chk({tag, "_b"}, ex_operand_b, 32'd0);
    chk({tag, "_st"}, ex_store_data, 32'd0);
  endtask

  // class, funct, opcode, expected op
  logic [1:0] t_cls [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
  logic [5:0] t_fn  [8] = '{6'h20, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h3F, 6'h3F};
  logic [5:0] t_opc [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h23, 6'h04};
  logic [3:0] t_exp [8] = '{4'd2, 4'd0, 4'd1, 4'd7, 4'd2, 4'd0, 4'd2, 4'd6};

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 6'h20, 6'h00, 32'h11, 32'h22, 32'h33, 1'b0, 5'd7);
    stall = 1'b0; flush = 1'b0;
    fwd_a = 2'b10; fwd_b = 2'b01;
    ex_mem_data = 32'hDEAD_BEEF; mem_wb_data = 32'hCAFE_F00D;
    step();
    step();
    chk_bubble("reset");
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("reset_cnt", {16'd0, illegal_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    fwd_a = 2'b00; fwd_b = 2'b00;

    drive(1'b1, 2'b10, 6'h22, 6'h00, 32'd9, 32'd4, 32'd0, 1'b0, 5'd3);
    step();
    chk("sub_valid", {31'd0, ex_valid}, 32'd1);
    chk("sub_op", {28'd0, ex_alu_op}, 32'd6);
    chk("sub_a", ex_operand_a, 32'd9);
    chk("sub_b", ex_operand_b, 32'd4);
    chk("sub_st", ex_store_data, 32'd4);
    chk("sub_dest", {27'd0, ex_dest}, 32'd3);

    drive(1'b1, 2'b11, 6'h00, 6'h0D, 32'h00F0, 32'h1234, 32'h000F, 1'b1, 5'd12);
    step();
    chk("ori_op", {28'd0, ex_alu_op}, 32'd1);
    chk("ori_a", ex_operand_a, 32'h00F0);
    chk("ori_b", ex_operand_b, 32'h000F);
    chk("ori_st", ex_store_data, 32'h1234);
    chk("ori_dest", {27'd0, ex_dest}, 32'd12);
    chk("ori_ill", {31'd0, ex_illegal}, 32'd0);

    drive(1'b1, 2'b10, 6'h27, 6'h00, 32'd1, 32'd2, 32'd0, 1'b0, 5'd5);
    step();
    chk("nor_op", {28'd0, ex_alu_op}, 32'hF);
    chk("nor_ill", {31'd0, ex_illegal}, 32'd1);
    chk("nor_valid", {31'd0, ex_valid}, 32'd1);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("cnt_one", {16'd0, illegal_cnt}, 32'd1);
`endif

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_cls[i], t_fn[i], t_opc[i], 32'd100 + i, 32'd200 + i, 32'd0, 1'b0, 5'(i));
      step();
      chk($sformatf("dec%0d_op", i), {28'd0, ex_alu_op}, {28'd0, t_exp[i]});
      chk($sformatf("dec%0d_ill", i), {31'd0, ex_illegal}, 32'd0);
    end

    drive(1'b1, 2'b00, 6'h00, 6'h23, 32'd3, 32'd8, 32'd5, 1'b1, 5'd9);
    step();
    drive(1'b1, 2'b10, 6'h30, 6'h00, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b0, 5'd30);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_op", i), {28'd0, ex_alu_op}, 32'd2);
      chk($sformatf("stall%0d_a", i), ex_operand_a, 32'd3);
      chk($sformatf("stall%0d_b", i), ex_operand_b, 32'd5);
      chk($sformatf("stall%0d_dest", i), {27'd0, ex_dest}, 32'd9);
    end
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("cnt_stall", {16'd0, illegal_cnt}, 32'd1);
`endif
    ex_mem_data = 32'h55; mem_wb_data = 32'h77;
    fwd_a = 2'b10; fwd_b = 2'b01;
    #1;
    chk("fwd_a_exmem", ex_operand_a, 32'h55);
    chk("fwd_b_imm", ex_operand_b, 32'd5);
    chk("fwd_st_memwb", ex_store_data, 32'h77);
    fwd_a = 2'b01; fwd_b = 2'b10;
    #1;
    chk("fwd_a_memwb", ex_operand_a, 32'h77);
    chk("fwd_st_exmem", ex_store_data, 32'h55);
    fwd_a = 2'b11; fwd_b = 2'b11;
    #1;
    chk("fwd_a_11", ex_operand_a, 32'd3);
    chk("fwd_st_11", ex_store_data, 32'd8);

    stall = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b10;
    drive(1'b1, 2'b01, 6'h00, 6'h04, 32'd40, 32'd10, 32'd0, 1'b0, 5'd2);
    step();
    chk("beq_op", {28'd0, ex_alu_op}, 32'd6);
    chk("beq_b_fwd", ex_operand_b, 32'h55);
    fwd_b = 2'b00;

    stall = 1'b1; flush = 1'b1;
    step();
    fwd_a = 2'b10; fwd_b = 2'b01;
    #1;
    chk_bubble("flush");
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    drive(1'b1, 2'b11, 6'h00, 6'h3E, 32'd0, 32'd0, 32'd0, 1'b0, 5'd1);
    step();
    chk("cnt_flush", {16'd0, illegal_cnt}, 32'd1);
`endif
    stall = 1'b0; flush = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00;

    drive(1'b1, 2'b10, 6'h25, 6'h00, 32'd6, 32'd7, 32'd0, 1'b0, 5'd4);
    step();
    chk("or_valid", {31'd0, ex_valid}, 32'd1);
    drive(1'b0, 2'b10, 6'h20, 6'h00, 32'd6, 32'd7, 32'd0, 1'b0, 5'd4);
    step();
    chk_bubble("idle");

    drive(1'b1, 2'b10, 6'h2A, 6'h00, 32'd1, 32'd2, 32'd0, 1'b0, 5'd8);
    stall = 1'b1;
    step();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("pre_rst_valid2", {31'd0, ex_valid}, 32'd1);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_bubble("async_rst");
    #2;
    rst_n = 1'b1;
    stall = 1'b0;
    drive(1'b1, 2'b11, 6'h00, 6'h0A, 32'd5, 32'd6, 32'd9, 1'b1, 5'd17);
    step();
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    chk("post_rst_op", {28'd0, ex_alu_op}, 32'd7);
    chk("post_rst_b", ex_operand_b, 32'd9);

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("cnt_after_rst", {16'd0, illegal_cnt}, 32'd0);
    drive(1'b1, 2'b10, 6'h27, 6'h00, 32'd0, 32'd0, 32'd0, 1'b0, 5'd1);
    for (int i = 0; i < 65540; i++) step();
    chk("cnt_sat", {16'd0, illegal_cnt}, 32'hFFFF);
    step();
    chk("cnt_sat_hold", {16'd0, illegal_cnt}, 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
